// File: rtl/acs_unit.sv
// acs_unit: add-compare-select stage of the rate-1/2, K=3 Viterbi decoder
// (generators 7/5 octal, four trellis states).
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   sync              frame restart: metrics, survivors and pointer reinit
//   valid_in          rx_symbol is valid this cycle
//   rx_symbol[1:0]    hard symbol, [1]=G0(111) bit, [0]=G1(101) bit
//   updated_selected_branch_at_xx  survivor path per state (newest bit LSB)
//   new_branch_metric_xx           normalized, saturated path metric
//   write_pointer_out              accepted symbols mod 8
//   valid_out                      one-cycle strobe per processed symbol
module acs_unit #(
  parameter int PM_W     = 4,
  parameter int SURV_LEN = 8,
  parameter int PM_INIT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sync,
  input  logic                valid_in,
  input  logic [1:0]          rx_symbol,
  output logic [SURV_LEN-1:0] updated_selected_branch_at_00,
  output logic [SURV_LEN-1:0] updated_selected_branch_at_01,
  output logic [SURV_LEN-1:0] updated_selected_branch_at_10,
  output logic [SURV_LEN-1:0] updated_selected_branch_at_11,
  output logic [PM_W-1:0]     new_branch_metric_00,
  output logic [PM_W-1:0]     new_branch_metric_01,
  output logic [PM_W-1:0]     new_branch_metric_10,
  output logic [PM_W-1:0]     new_branch_metric_11,
  output logic [2:0]          write_pointer_out,
  output logic                valid_out
);

  localparam int CW = PM_W + 1;
  localparam logic [PM_W-1:0] PM_INIT_V = PM_W'(PM_INIT);
  localparam logic [CW-1:0]   PM_MAX    = CW'((1 << PM_W) - 1);

  logic [PM_W-1:0]     pm_q   [4];
  logic [SURV_LEN-1:0] surv_q [4];
  logic [2:0]          wp_q;
  logic                vld_q;

  logic [CW-1:0]       cand   [4];
  logic [SURV_LEN-1:0] surv_n [4];
  logic [PM_W-1:0]     pm_n   [4];
  logic [CW-1:0]       cmin;
  logic [CW-1:0]       min_lo;
  logic [CW-1:0]       min_hi;

  // Hamming distance between the encoder output for input u leaving
  // state p and the received symbol.
  function automatic logic [1:0] bm_f(
    input logic [1:0] p,
    input logic       u,
    input logic [1:0] rx
  );
    logic c0;
    logic c1;
    c0 = u ^ p[1] ^ p[0];
    c1 = u ^ p[0];
    return {1'b0, c0 ^ rx[1]} + {1'b0, c1 ^ rx[0]};
  endfunction

  // Next state {u,x} is reached from {x,0} (pa) or {x,1} (pb).
  for (genvar s = 0; s < 4; s++) begin : g_st
    localparam int         UI = s / 2;
    localparam int         XI = s % 2;
    localparam logic       U  = 1'(UI);
    localparam logic [1:0] PA = 2'(2 * XI);
    localparam logic [1:0] PB = 2'(2 * XI + 1);

    logic [CW-1:0]       ca;
    logic [CW-1:0]       cb;
    logic                take_b;
    logic [SURV_LEN-1:0] sp;

    assign ca = {1'b0, pm_q[PA]} + CW'(bm_f(PA, U, rx_symbol));
    assign cb = {1'b0, pm_q[PB]} + CW'(bm_f(PB, U, rx_symbol));
    // strict compare: ties resolve to the b0=0 predecessor
    assign take_b    = cb < ca;
    assign cand[s]   = take_b ? cb : ca;
    assign sp        = take_b ? surv_q[PB] : surv_q[PA];
    assign surv_n[s] = {sp[SURV_LEN-2:0], U};
  end

  assign min_lo = (cand[1] < cand[0]) ? cand[1] : cand[0];
  assign min_hi = (cand[3] < cand[2]) ? cand[3] : cand[2];
  assign cmin   = (min_hi < min_lo) ? min_hi : min_lo;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pm_n[i] = '0;
      if ((cand[i] - cmin) > PM_MAX) begin
        pm_n[i] = PM_MAX[PM_W-1:0];
      end else begin
        pm_n[i] = PM_W'(cand[i] - cmin);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_INIT_V;
        surv_q[i] <= '0;
      end
      wp_q  <= '0;
      vld_q <= 1'b0;
    end else if (sync) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_INIT_V;
        surv_q[i] <= '0;
      end
      wp_q  <= '0;
      vld_q <= 1'b0;
    end else if (valid_in) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= pm_n[i];
        surv_q[i] <= surv_n[i];
      end
      wp_q  <= wp_q + 3'd1;
      vld_q <= 1'b1;
    end else begin
      vld_q <= 1'b0;
    end
  end

  assign updated_selected_branch_at_00 = surv_q[0];
  assign updated_selected_branch_at_01 = surv_q[1];
  assign updated_selected_branch_at_10 = surv_q[2];
  assign updated_selected_branch_at_11 = surv_q[3];
  assign new_branch_metric_00          = pm_q[0];
  assign new_branch_metric_01          = pm_q[1];
  assign new_branch_metric_10          = pm_q[2];
  assign new_branch_metric_11          = pm_q[3];
  assign write_pointer_out             = wp_q;
  assign valid_out                     = vld_q;

endmodule

// File: doc/acs_unit.md
Name: acs_unit

Overview:
Add-compare-select stage of the rate-1/2, K=3 Viterbi decoder (generators 7 and 5 octal, 4 trellis states). Per accepted received symbol it:
- computes Hamming branch metrics,
- updates four normalized, saturating path metrics,
- extends the four survivor-path registers.

It feeds the selector stage directly: survivors, path metrics, write pointer and a one-cycle valid strobe.

Parameters:
PM_W, 4, path-metric width; must match the selector metric ports.
SURV_LEN, 8, survivor register length in bits; must match the selector branch ports.
PM_INIT, 15, initial metric of states 01/10/11 after reset or sync; state 00 starts at 0.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
sync  in  1  frame restart; reinitializes metrics, survivors and pointer
valid_in  in  1  rx_symbol valid this cycle
rx_symbol  in  2  received hard symbol; [1]=G0(111) bit, [0]=G1(101) bit
updated_selected_branch_at_00..11  out  SURV_LEN each  survivor path per state
new_branch_metric_00..11  out  PM_W each  normalized path metric per state
write_pointer_out  out  3  count of accepted symbols, mod 8
valid_out  out  1  one-cycle strobe: outputs reflect a newly processed symbol

Behaviour:
- Reset (rst=1, async):
  - metric 00 = 0; metrics 01/10/11 = PM_INIT.
  - All survivors = 0; write_pointer_out = 0; valid_out = 0.
- State encoding {b1,b0}: b1 is the most recent input bit, b0 the one before.
- Encoder for input u from state {b1,b0}:
  - c0 = u^b1^b0; c1 = u^b0.
  - Next state = {u,b1}.
  - Predecessors of next state {u,x} are {x,0} and {x,1}.
- Branch metric = Hamming distance({c0,c1}, rx_symbol), range 0..2.
- Add: candidate = pm(pred) + bm, held at PM_W+1 bits (max 17, no overflow).
- Compare/select:
  - Keep the smaller candidate.
  - Tie: take the predecessor with b0=0.
- Survivor update: new_surv[state {u,x}] = {surv[selected pred][SURV_LEN-2:0], u}. Newest bit in the LSB; the oldest bit is shifted out.
- Normalize:
  - Subtract the minimum of the four selected candidates from all four, so some metric is always 0.
  - Saturate results above 2^PM_W-1 to 2^PM_W-1.
- Latency and handshake:
  - valid_in sampled high at edge N → all outputs updated at edge N and valid_out=1 during cycle N..N+1.
  - Single-cycle ACS; accepts a symbol every cycle with no backpressure.
- valid_in low: metrics, survivors and pointer hold; valid_out=0.
- write_pointer_out increments by 1 per accepted symbol and wraps 7→0.
- sync=1 at an edge:
  - Apply the reset values synchronously; valid_out=0.
  - sync has priority over a simultaneous valid_in; that symbol is discarded.
- Reset asserted mid-stream: immediate return to reset values. The first valid_in after release is processed against the initial metrics.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then rx_symbol=00 with valid_in for 1 cycle:
   - metrics 00/01/10/11 = 0/15/2/15.
   - Survivors at 00 = 0x00 and 10 = 0x01.
   - write_pointer_out = 1; valid_out high exactly 1 cycle.
2. Error-free sequence 11,10,00,01 (input bits 1,0,1,1) after sync:
   - metric 11 = 0 and is the unique minimum.
   - updated_selected_branch_at_11[3:0] = 4'b1011; write_pointer_out = 4.
3. Eight consecutive 00 symbols:
   - metric 00 = 0; survivor at 00 = 0x00.
   - write_pointer_out wraps back to 0; valid_out pulses 8 times.
4. 20 symbols of 11 from reset (all-ones input; the encoder reaches state 11 and emits 10 repeatedly):
   - No metric ever exceeds 15; at least one metric is 0 every cycle; no wrap-around corruption.
5. Tie case (symbol 00 from reset, state 01): candidates equal (16/16), so the predecessor with b0=0 (state 10) is chosen; check survivor at 01 = 0x00.
6. Interface edge cases:
   - valid_in and sync high together: reset values result, valid_out=0.
   - rst pulsed for 1 cycle mid-stream with valid_in held high: outputs return to reset values immediately; processing resumes from the initial metrics on the next edge after release.
   - valid_in low for 5 cycles: all outputs unchanged.
